// File: rtl/zacore_pkg.sv
// ============================================================================
// Module : zacore_pkg
// Brief  : Shared types and constants for the zacore memory arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package zacore_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        FETCH = 1'b0,
        DATA  = 1'b1
    } requester_t;

    localparam logic [31:0] ZACORE_BUS_ERR_DATA = 32'hDEADBEEF;

endpackage

`default_nettype wire

// File: rtl/zacore_mem_arbiter_if.sv
// ============================================================================
// Module : zacore_mem_arbiter_if
// Brief  : Core request/response and shared memory port bundle. The slave
//          modport is the arbiter's view; master is the core/memory side.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface zacore_mem_arbiter_if;
    logic        i_fetch_req;
    logic [31:0] i_fetch_addr;
    logic        o_fetch_ack;
    logic [31:0] o_inst_read;
    logic        i_read_req;
    logic        i_write_req;
    logic [31:0] i_data_addr;
    logic [31:0] i_data_write;
    logic [3:0]  i_data_write_mask;
    logic        o_read_ack;
    logic        o_write_ack;
    logic [31:0] o_data_read;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_wmask;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;
    logic        o_bus_err;

    modport slave (
        input  i_fetch_req, i_fetch_addr, i_read_req, i_write_req,
        input  i_data_addr, i_data_write, i_data_write_mask,
        input  i_mem_ack, i_mem_rdata,
        output o_fetch_ack, o_inst_read, o_read_ack, o_write_ack, o_data_read,
        output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wmask,
        output o_bus_err
    );

    modport master (
        output i_fetch_req, i_fetch_addr, i_read_req, i_write_req,
        output i_data_addr, i_data_write, i_data_write_mask,
        output i_mem_ack, i_mem_rdata,
        input  o_fetch_ack, o_inst_read, o_read_ack, o_write_ack, o_data_read,
        input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wmask,
        input  o_bus_err
    );
endinterface

`default_nettype wire

// File: rtl/zacore_mem_arb_timeout.sv
// ============================================================================
// Module : zacore_mem_arb_timeout
// Brief  : BUSY-phase watchdog; compiled only with ZACORE_ARB_TIMEOUT_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifdef ZACORE_ARB_TIMEOUT_EN
module zacore_mem_arb_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  wire logic i_clk,
    input  wire logic i_rst,
    input  wire logic i_start,
    input  wire logic i_busy,
    input  wire logic i_mem_ack,
    output logic      o_timeout
);
    localparam logic [15:0] c_timeout_limit = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] count_q;
    logic [15:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_start) begin
            count_d = 16'd0;
        end else if (i_busy && !i_mem_ack) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q <= 16'd0;
        end else begin
            count_q <= count_d;
        end
    end

    // Fires during the TIMEOUT_CYCLES-th BUSY cycle; a same-cycle ack wins.
    assign o_timeout = i_busy && !i_mem_ack && (count_q == c_timeout_limit);
endmodule
`endif

`default_nettype wire

// File: rtl/zacore_mem_arbiter.sv
// ============================================================================
// Module : zacore_mem_arbiter
// Brief  : Round-robin fetch/data arbiter onto one registered memory port.
//          Optional BUSY timeout abort enabled by macro ZACORE_ARB_TIMEOUT_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module zacore_mem_arbiter
    import zacore_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  wire logic            i_clk,
    input  wire logic            i_rst,
    zacore_mem_arbiter_if.slave  bus
);
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be within 2..65535");
    end

    arb_state_t  state_q, state_d;
    requester_t  gnt_q, gnt_d;
    requester_t  rr_last_q, rr_last_d;
    requester_t  w_sel;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_wmask_q, mem_wmask_d;
    logic        fetch_ack_q, fetch_ack_d;
    logic        read_ack_q, read_ack_d;
    logic        write_ack_q, write_ack_d;
    logic        bus_err_q, bus_err_d;
    logic [31:0] inst_read_q, inst_read_d;
    logic [31:0] data_read_q, data_read_d;
    logic        w_fetch_pend;
    logic        w_data_pend;
    logic        w_start;
    logic        w_timeout;
    logic        w_done;
    logic [31:0] w_rdata;

    assign w_fetch_pend = bus.i_fetch_req;
    assign w_data_pend  = bus.i_read_req | bus.i_write_req;
    assign w_done       = bus.i_mem_ack | w_timeout;
    assign w_rdata      = bus.i_mem_ack ? bus.i_mem_rdata : ZACORE_BUS_ERR_DATA;

`ifdef ZACORE_ARB_TIMEOUT_EN
    zacore_mem_arb_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_start   (w_start),
        .i_busy    (state_q == BUSY),
        .i_mem_ack (bus.i_mem_ack),
        .o_timeout (w_timeout)
    );
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        rr_last_d   = rr_last_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wmask_d = mem_wmask_q;
        fetch_ack_d = 1'b0;
        read_ack_d  = 1'b0;
        write_ack_d = 1'b0;
        bus_err_d   = 1'b0;
        inst_read_d = inst_read_q;
        data_read_d = data_read_q;
        w_start     = 1'b0;
        // The pointer only remembers the winner of a contested arbitration.
        w_sel       = (w_fetch_pend && (!w_data_pend || rr_last_q == DATA)) ? FETCH : DATA;

        case (state_q)
            IDLE: begin
                if (w_fetch_pend || w_data_pend) begin
                    w_start   = 1'b1;
                    state_d   = BUSY;
                    gnt_d     = w_sel;
                    mem_req_d = 1'b1;
                    if (w_fetch_pend && w_data_pend) begin
                        rr_last_d = w_sel;
                    end
                    if (w_sel == FETCH) begin
                        mem_addr_d  = bus.i_fetch_addr;
                        mem_we_d    = 1'b0;
                        mem_wmask_d = 4'h0;
                    end else begin
                        mem_addr_d  = bus.i_data_addr;
                        mem_we_d    = bus.i_write_req;
                        mem_wmask_d = bus.i_write_req ? bus.i_data_write_mask : 4'h0;
                        if (bus.i_write_req) begin
                            mem_wdata_d = bus.i_data_write;
                        end
                    end
                end
            end
            BUSY: begin
                if (w_done) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    bus_err_d = ~bus.i_mem_ack;
                    if (gnt_q == FETCH) begin
                        fetch_ack_d = 1'b1;
                        inst_read_d = w_rdata;
                    end else if (mem_we_q) begin
                        write_ack_d = 1'b1;
                    end else begin
                        read_ack_d  = 1'b1;
                        data_read_d = w_rdata;
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            gnt_q       <= FETCH;
            rr_last_q   <= DATA;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            mem_wmask_q <= 4'h0;
            fetch_ack_q <= 1'b0;
            read_ack_q  <= 1'b0;
            write_ack_q <= 1'b0;
            bus_err_q   <= 1'b0;
            inst_read_q <= 32'h0;
            data_read_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            rr_last_q   <= rr_last_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wmask_q <= mem_wmask_d;
            fetch_ack_q <= fetch_ack_d;
            read_ack_q  <= read_ack_d;
            write_ack_q <= write_ack_d;
            bus_err_q   <= bus_err_d;
            inst_read_q <= inst_read_d;
            data_read_q <= data_read_d;
        end
    end

    assign bus.o_mem_req   = mem_req_q;
    assign bus.o_mem_we    = mem_we_q;
    assign bus.o_mem_addr  = mem_addr_q;
    assign bus.o_mem_wdata = mem_wdata_q;
    assign bus.o_mem_wmask = mem_wmask_q;
    assign bus.o_fetch_ack = fetch_ack_q;
    assign bus.o_read_ack  = read_ack_q;
    assign bus.o_write_ack = write_ack_q;
    assign bus.o_bus_err   = bus_err_q;
    assign bus.o_inst_read = inst_read_q;
    assign bus.o_data_read = data_read_q;
endmodule

`default_nettype wire

// File: tb/tb_zacore_mem_arbiter.sv
// ============================================================================
// Module : tb_zacore_mem_arbiter
// Brief  : Directed self-checking bench for zacore_mem_arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_zacore_mem_arbiter;
`ifdef ZACORE_ARB_TIMEOUT_EN
    localparam int unsigned TB_TIMEOUT = 8;
`else
    localparam int unsigned TB_TIMEOUT = 1024;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    zacore_mem_arbiter_if bus ();

    zacore_mem_arbiter #(
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for a memory request, then acks it one cycle later; returns in the RESP cycle.
    task automatic mem_serve(input logic [31:0] rdata, output logic [31:0] addr, output logic we);
        int n = 0;
        while (!bus.o_mem_req && n < 20) begin
            tick();
            n++;
        end
        check("mem_req_seen", {31'h0, bus.o_mem_req}, 32'd1);
        addr = bus.o_mem_addr;
        we   = bus.o_mem_we;
        tick();
        bus.i_mem_ack   = 1'b1;
        bus.i_mem_rdata = rdata;
        tick();
        bus.i_mem_ack   = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},   {31'h0, bus.o_mem_req},   32'd0);
        check({tag, "_acks"},  {29'h0, bus.o_fetch_ack, bus.o_read_ack, bus.o_write_ack}, 32'd0);
        check({tag, "_err"},   {31'h0, bus.o_bus_err},   32'd0);
        check({tag, "_addr"},  bus.o_mem_addr,           32'd0);
        check({tag, "_wdata"}, bus.o_mem_wdata,          32'd0);
        check({tag, "_wmask"}, {28'h0, bus.o_mem_wmask}, 32'd0);
        check({tag, "_we"},    {31'h0, bus.o_mem_we},    32'd0);
        check({tag, "_inst"},  bus.o_inst_read,          32'd0);
        check({tag, "_dread"}, bus.o_data_read,          32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        logic        we;

        bus.i_fetch_req = 0; bus.i_fetch_addr = 0; bus.i_read_req = 0; bus.i_write_req = 0;
        bus.i_data_addr = 0; bus.i_data_write = 0; bus.i_data_write_mask = 0;
        bus.i_mem_ack = 0;   bus.i_mem_rdata = 0;

        rst = 1'b1;
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;

        // Single fetch, memory acks one cycle after o_mem_req; request held through ack.
        bus.i_fetch_req = 1'b1; bus.i_fetch_addr = 32'h10;
        tick();
        check("f_req_n1",  {31'h0, bus.o_mem_req}, 32'd1);
        check("f_addr_n1", bus.o_mem_addr, 32'h10);
        check("f_we_n1",   {31'h0, bus.o_mem_we}, 32'd0);
        check("f_mask_n1", {28'h0, bus.o_mem_wmask}, 32'd0);
        tick();
        check("f_req_n2", {31'h0, bus.o_mem_req}, 32'd1);
        check("f_ack_n2", {31'h0, bus.o_fetch_ack}, 32'd0);
        bus.i_mem_ack = 1'b1; bus.i_mem_rdata = 32'h12345678;
        tick();
        bus.i_mem_ack = 1'b0;
        check("f_ack_n3",  {31'h0, bus.o_fetch_ack}, 32'd1);
        check("f_inst_n3", bus.o_inst_read, 32'h12345678);
        check("f_req_n3",  {31'h0, bus.o_mem_req}, 32'd0);
        check("f_rack_n3", {31'h0, bus.o_read_ack}, 32'd0);
        tick();
        check("f_ack_n4",   {31'h0, bus.o_fetch_ack}, 32'd0);
        check("f_noregrant", {31'h0, bus.o_mem_req}, 32'd0);
        check("f_inst_hold", bus.o_inst_read, 32'h12345678);
        bus.i_fetch_req = 1'b0;
        tick();
        check("f_idle_req", {31'h0, bus.o_mem_req}, 32'd0);

        // Stray ack while idle is ignored.
        bus.i_mem_ack = 1'b1; bus.i_mem_rdata = 32'hFFFFFFFF;
        tick();
        bus.i_mem_ack = 1'b0;
        tick();
        check("stray_acks", {29'h0, bus.o_fetch_ack, bus.o_read_ack, bus.o_write_ack}, 32'd0);
        check("stray_req",  {31'h0, bus.o_mem_req}, 32'd0);
        check("stray_inst", bus.o_inst_read, 32'h12345678);

        // Round-robin from reset: fetch then read, then read then fetch.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.i_fetch_req = 1'b1; bus.i_fetch_addr = 32'h100;
        bus.i_read_req  = 1'b1; bus.i_data_addr  = 32'h200;
        mem_serve(32'hAAAA0001, a, we);
        check("rr1_first",  a, 32'h100);
        check("rr1_fack",   {31'h0, bus.o_fetch_ack}, 32'd1);
        check("rr1_rack0",  {31'h0, bus.o_read_ack}, 32'd0);
        check("rr1_inst",   bus.o_inst_read, 32'hAAAA0001);
        bus.i_fetch_req = 1'b0;
        mem_serve(32'hBBBB0002, a, we);
        check("rr1_second", a, 32'h200);
        check("rr1_rack",   {31'h0, bus.o_read_ack}, 32'd1);
        check("rr1_dread",  bus.o_data_read, 32'hBBBB0002);
        bus.i_read_req = 1'b0;
        tick();
        bus.i_fetch_req = 1'b1; bus.i_fetch_addr = 32'h104;
        bus.i_read_req  = 1'b1; bus.i_data_addr  = 32'h204;
        mem_serve(32'hCCCC0003, a, we);
        check("rr2_first", a, 32'h204);
        check("rr2_rack",  {31'h0, bus.o_read_ack}, 32'd1);
        check("rr2_fack0", {31'h0, bus.o_fetch_ack}, 32'd0);
        bus.i_read_req = 1'b0;
        mem_serve(32'hDDDD0004, a, we);
        check("rr2_second", a, 32'h104);
        check("rr2_fack",   {31'h0, bus.o_fetch_ack}, 32'd1);
        check("rr2_inst",   bus.o_inst_read, 32'hDDDD0004);
        bus.i_fetch_req = 1'b0;
        tick();

        // Write with a slow memory: port must stay stable while BUSY.
        bus.i_write_req = 1'b1; bus.i_data_addr = 32'h20;
        bus.i_data_write = 32'hA5A5A5A5; bus.i_data_write_mask = 4'b0101;
        tick();
        check("w_we",    {31'h0, bus.o_mem_we}, 32'd1);
        check("w_mask",  {28'h0, bus.o_mem_wmask}, 32'h5);
        check("w_wdata", bus.o_mem_wdata, 32'hA5A5A5A5);
        check("w_addr",  bus.o_mem_addr, 32'h20);
        tick(); tick(); tick();
        check("w_req_hold",  {31'h0, bus.o_mem_req}, 32'd1);
        check("w_addr_hold", bus.o_mem_addr, 32'h20);
        bus.i_mem_ack = 1'b1; bus.i_mem_rdata = 32'h0;
        tick();
        bus.i_mem_ack = 1'b0;
        check("w_wack", {31'h0, bus.o_write_ack}, 32'd1);
        check("w_rack", {31'h0, bus.o_read_ack}, 32'd0);
        bus.i_write_req = 1'b0;
        tick();
        check("w_wack_pulse", {31'h0, bus.o_write_ack}, 32'd0);

        // Read and write together behave as a write.
        bus.i_read_req = 1'b1; bus.i_write_req = 1'b1; bus.i_data_addr = 32'h30;
        bus.i_data_write = 32'h11223344; bus.i_data_write_mask = 4'hF;
        mem_serve(32'h99999999, a, we);
        check("rw_we",   {31'h0, we}, 32'd1);
        check("rw_wack", {31'h0, bus.o_write_ack}, 32'd1);
        check("rw_rack", {31'h0, bus.o_read_ack}, 32'd0);
        bus.i_read_req = 1'b0; bus.i_write_req = 1'b0;
        tick();

`ifdef ZACORE_ARB_TIMEOUT_EN
        // Memory never acks: abort after TIMEOUT_CYCLES BUSY cycles.
        bus.i_read_req = 1'b1; bus.i_data_addr = 32'h40;
        tick();
        for (int i = 2; i <= 8; i++) tick();
        check("to_req_b8", {31'h0, bus.o_mem_req}, 32'd1);
        tick();
        check("to_req_drop", {31'h0, bus.o_mem_req}, 32'd0);
        check("to_rack",     {31'h0, bus.o_read_ack}, 32'd1);
        check("to_err",      {31'h0, bus.o_bus_err}, 32'd1);
        check("to_dread",    bus.o_data_read, 32'hDEADBEEF);
        bus.i_read_req = 1'b0;
        tick();
        check("to_err_pulse", {31'h0, bus.o_bus_err}, 32'd0);

        // Ack arriving in the timeout cycle wins.
        bus.i_read_req = 1'b1; bus.i_data_addr = 32'h44;
        tick();
        for (int i = 2; i <= 8; i++) tick();
        bus.i_mem_ack = 1'b1; bus.i_mem_rdata = 32'h600DF00D;
        tick();
        bus.i_mem_ack = 1'b0;
        check("race_rack",  {31'h0, bus.o_read_ack}, 32'd1);
        check("race_err",   {31'h0, bus.o_bus_err}, 32'd0);
        check("race_dread", bus.o_data_read, 32'h600DF00D);
        bus.i_read_req = 1'b0;
        tick();
`endif

        // Reset while BUSY, then a late ack: silent abort, fetch priority restored.
        bus.i_fetch_req = 1'b1; bus.i_fetch_addr = 32'h300;
        tick();
        check("rb_busy", {31'h0, bus.o_mem_req}, 32'd1);
        rst = 1'b1; bus.i_fetch_req = 1'b0;
        tick();
        rst = 1'b0;
        bus.i_mem_ack = 1'b1; bus.i_mem_rdata = 32'h55;
        tick();
        bus.i_mem_ack = 1'b0;
        check_reset_outputs("rb");
        bus.i_fetch_req = 1'b1; bus.i_fetch_addr = 32'h400;
        bus.i_read_req  = 1'b1; bus.i_data_addr  = 32'h500;
        mem_serve(32'h77777777, a, we);
        check("rb_fetch_first", a, 32'h400);
        check("rb_fack",        {31'h0, bus.o_fetch_ack}, 32'd1);
        bus.i_fetch_req = 1'b0; bus.i_read_req = 1'b0;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/zacore_mem_arbiter.md
ZACORE_MEM_ARBITER -- requirements
Module: zacore_mem_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024, is the BUSY cycles before forced abort; legal range 2..65535.
REQ-002 i_clk  in  1  sole clock; all state updates on posedge.
REQ-003 i_rst  in  1  reset, synchronous, active-high.
REQ-004 i_fetch_req  in  1  core instruction fetch request, held until o_fetch_ack.
REQ-005 i_fetch_addr  in  32  fetch word address, stable while i_fetch_req high.
REQ-006 o_fetch_ack  out  1  one-cycle fetch completion pulse.
REQ-007 o_inst_read  out  32  fetched word, valid while o_fetch_ack high.
REQ-008 i_read_req / i_write_req  in  1 each  core data read/write request, held until matching ack.
REQ-009 i_data_addr  in  32;  i_data_write  in  32;  i_data_write_mask  in  4  data address, store data, byte enables.
REQ-010 o_read_ack / o_write_ack  out  1 each  one-cycle data completion pulses.
REQ-011 o_data_read  out  32  load word, valid while o_read_ack high.
REQ-012 o_mem_req  out  1;  o_mem_we  out  1;  o_mem_addr  out  32;  o_mem_wdata  out  32;  o_mem_wmask  out  4  single shared memory port, all registered.
REQ-013 i_mem_ack  in  1;  i_mem_rdata  in  32  memory completion; rdata valid with ack.
REQ-014 o_bus_err  out  1  one-cycle pulse on timeout abort.

Function
REQ-015 FSM states: IDLE, BUSY, RESP; exactly one transaction in flight.
REQ-016 IDLE with any request in cycle N: grant, latch addr/data/mask/we, go BUSY; o_mem_req high from cycle N+1.
REQ-017 Fetch and data both pending in IDLE: round-robin, grant the requester not granted last; after reset, fetch wins first.
REQ-018 i_read_req and i_write_req both high: treated as write, no read issued.
REQ-019 BUSY: hold o_mem_req and all o_mem_* stable until the cycle M with i_mem_ack high.
REQ-020 At M+1: state RESP, o_mem_req low, matching ack pulses one cycle, read data registered from i_mem_rdata at M.
REQ-021 RESP always returns to IDLE next cycle; requests are not sampled in RESP, so a stale held req is never re-granted.
REQ-022 Minimum round trip: req cycle N, ack N+2, next grant sampled N+3.
REQ-023 i_mem_ack while not BUSY: ignored.
REQ-024 o_mem_we=0 and o_mem_wmask=4'h0 for fetch and read transactions.
REQ-025 o_inst_read/o_data_read hold their last value when not acked; o_mem_addr/wdata hold their last latched value when idle.

Reset
REQ-026 i_rst high at a posedge: state IDLE; o_mem_req, o_mem_we, all acks, o_bus_err = 0; o_mem_addr, o_mem_wdata, o_inst_read, o_data_read = 0; o_mem_wmask = 0; round-robin pointer = fetch-first; timeout counter = 0.
REQ-027 Reset mid-transaction: abort silently, no ack or o_bus_err issued; a late i_mem_ack is ignored per REQ-023.

Configuration
REQ-028 Macro ZACORE_ARB_TIMEOUT_EN defined: a 16-bit counter clears on BUSY entry and increments each BUSY cycle without i_mem_ack; reaching TIMEOUT_CYCLES drops o_mem_req, enters RESP, pulses the requester's ack and o_bus_err, and returns read data 32'hDEADBEEF.
REQ-029 Macro undefined: no counter, BUSY waits indefinitely, o_bus_err tied 0.
REQ-030 i_mem_ack in the same cycle as the timeout: the ack wins, normal completion, no o_bus_err.

Structure
REQ-031 zacore_pkg holds the arb_state_t enum (IDLE/BUSY/RESP), the requester_t enum (FETCH/DATA), and the constant ZACORE_BUS_ERR_DATA = 32'hDEADBEEF.
REQ-032 The timeout counter is sub-module zacore_mem_arb_timeout, instantiated only under ZACORE_ARB_TIMEOUT_EN.

Verification
REQ-033 Fetch only, addr 0x10, memory acks 1 cycle after o_mem_req, rdata 0x12345678 -> o_fetch_ack at N+3, o_inst_read=0x12345678, o_mem_we=0.
REQ-034 Fetch and read both asserted from reset -> fetch granted first, read second; repeat both -> read first, then fetch (alternation).
REQ-035 Write addr 0x20, data 0xA5A5A5A5, mask 4'b0101 -> o_mem_we=1, o_mem_wmask=4'b0101, o_write_ack one cycle, no o_read_ack.
REQ-036 Request held high through ack -> exactly one o_mem_req transaction, RESP blocks re-grant.
REQ-037 With ZACORE_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, memory never acks a read -> o_mem_req drops after 8 BUSY cycles, o_read_ack and o_bus_err pulse, o_data_read=0xDEADBEEF.
REQ-038 i_rst asserted while BUSY, then i_mem_ack -> no ack or o_bus_err, all outputs at reset values, next request starts with fetch priority.
